// File: rtl/apuf_eval_ctrl.sv
// Evaluation controller for multi-chain arbiter PUFs: sequences arbiter reset and launch,
// samples every chain N_EVAL times and reports majority response, stability and XOR.
module apuf_eval_ctrl #(
  parameter int CHAL_WIDTH    = 32,
  parameter int NUM_CHAINS    = 1,
  parameter int N_EVAL        = 5,
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [CHAL_WIDTH-1:0] Challenge,
  input  logic [NUM_CHAINS-1:0] ArbResult,
  output logic [CHAL_WIDTH-1:0] PufChallenge,
  output logic                  Pulse,
  output logic                  ArbReset,
  output logic                  Busy,
  output logic                  Done,
  output logic [NUM_CHAINS-1:0] Response,
  output logic                  XorResponse,
  output logic [NUM_CHAINS-1:0] Stable
);

  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int VW   = $clog2(N_EVAL + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0] VMAX     = VW'(N_EVAL);
  localparam logic [VW-1:0] HALF     = VW'(N_EVAL / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB_RST,
    S_LAUNCH,
    S_SAMPLE,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [TW-1:0]                  timer_q, timer_d;
  logic [VW-1:0]                  eval_q, eval_d;
  logic [CHAL_WIDTH-1:0]          chal_q, chal_d;
  logic [NUM_CHAINS-1:0][VW-1:0]  vote_q, vote_d;
  logic [NUM_CHAINS-1:0]          sync1_q, sync2_q;
  logic [NUM_CHAINS-1:0]          resp_q, resp_d;
  logic [NUM_CHAINS-1:0]          stab_q, stab_d;
  logic                           xr_q;
  logic                           done_q;
  logic                           clr_votes;
  logic                           do_sample;
  logic                           load_results;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    eval_d    = eval_q;
    chal_d    = chal_q;
    clr_votes = 1'b0;
    do_sample = 1'b0;
    ArbReset  = 1'b1;
    Pulse     = 1'b0;
    Busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          chal_d    = Challenge;
          clr_votes = 1'b1;
          eval_d    = '0;
          timer_d   = '0;
          state_d   = S_ARB_RST;
        end
      end
      S_ARB_RST: begin
        if (timer_q == RST_LAST) begin
          timer_d = '0;
          state_d = S_LAUNCH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        ArbReset = 1'b0;
        Pulse    = 1'b1;
        if (timer_q == SET_LAST) begin
          timer_d = '0;
          state_d = S_SAMPLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        ArbReset  = 1'b0;
        Pulse     = 1'b1;
        do_sample = 1'b1;
        eval_d    = eval_q + 1'b1;
        state_d   = S_RELEASE;
      end
      S_RELEASE: begin
        ArbReset = 1'b0;
        if (timer_q == SET_LAST) begin
          timer_d = '0;
          state_d = (eval_q < VMAX) ? S_ARB_RST : S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including the one into DONE.
    if (Abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      timer_d = '0;
    end
  end

  // Results are captured on the edge entering DONE so they are valid while Done is high.
  assign load_results = (state_d == S_DONE);

  for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
    assign vote_d[gi] = clr_votes ? '0 :
                        (do_sample && sync2_q[gi] && (vote_q[gi] != VMAX)) ? vote_q[gi] + 1'b1 :
                        vote_q[gi];
    assign resp_d[gi] = (vote_q[gi] > HALF);
    assign stab_d[gi] = (vote_q[gi] == '0) || (vote_q[gi] == VMAX);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      eval_q  <= '0;
      chal_q  <= '0;
      vote_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      resp_q  <= '0;
      stab_q  <= '0;
      xr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      eval_q  <= eval_d;
      chal_q  <= chal_d;
      vote_q  <= vote_d;
      sync1_q <= ArbResult;
      sync2_q <= sync1_q;
      done_q  <= load_results;
      if (load_results) begin
        resp_q <= resp_d;
        stab_q <= stab_d;
        xr_q   <= ^resp_d;
      end
    end
  end

  assign PufChallenge = chal_q;
  assign Done         = done_q;
  assign Response     = resp_q;
  assign Stable       = stab_q;
  assign XorResponse  = xr_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Bench for apuf_eval_ctrl: a cycle-numbered behavioural model checks two configurations every cycle,
// plus literal expectations for the directed scenarios.
module tb_apuf_eval_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        start_s [2];
  logic        abort_s [2];
  logic [31:0] chal_s  [2];
  logic [1:0]  arb_a;
  logic        arb_b;

  logic [31:0] pc_a, pc_b;
  logic        pulse_a, pulse_b, arbrst_a, arbrst_b, busy_a, busy_b, done_a, done_b;
  logic [1:0]  resp_a, stab_a;
  logic        resp_b, stab_b, xr_a, xr_b;

  apuf_eval_ctrl #(.NUM_CHAINS(2)) u_a (
    .Clk(clk), .Reset_n(rst_n), .Start(start_s[0]), .Abort(abort_s[0]),
    .Challenge(chal_s[0]), .ArbResult(arb_a), .PufChallenge(pc_a), .Pulse(pulse_a),
    .ArbReset(arbrst_a), .Busy(busy_a), .Done(done_a), .Response(resp_a),
    .XorResponse(xr_a), .Stable(stab_a)
  );

  apuf_eval_ctrl #(.NUM_CHAINS(1), .N_EVAL(1), .RST_CYCLES(1), .SETTLE_CYCLES(3)) u_b (
    .Clk(clk), .Reset_n(rst_n), .Start(start_s[1]), .Abort(abort_s[1]),
    .Challenge(chal_s[1]), .ArbResult(arb_b), .PufChallenge(pc_b), .Pulse(pulse_b),
    .ArbReset(arbrst_b), .Busy(busy_b), .Done(done_b), .Response(resp_b),
    .XorResponse(xr_b), .Stable(stab_b)
  );

  logic        o_busy [2], o_pulse [2], o_arbrst [2], o_done [2], o_xr [2];
  logic [1:0]  o_resp [2], o_stab [2];
  logic [31:0] o_pc   [2];
  assign o_busy[0] = busy_a;    assign o_busy[1] = busy_b;
  assign o_pulse[0] = pulse_a;  assign o_pulse[1] = pulse_b;
  assign o_arbrst[0] = arbrst_a; assign o_arbrst[1] = arbrst_b;
  assign o_done[0] = done_a;    assign o_done[1] = done_b;
  assign o_xr[0] = xr_a;        assign o_xr[1] = xr_b;
  assign o_resp[0] = resp_a;    assign o_resp[1] = {1'b0, resp_b};
  assign o_stab[0] = stab_a;    assign o_stab[1] = {1'b0, stab_b};
  assign o_pc[0] = pc_a;        assign o_pc[1] = pc_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Configuration of each instance.
  function automatic int ne(input int i);   return (i == 0) ? 5 : 1; endfunction
  function automatic int nc(input int i);   return (i == 0) ? 2 : 1; endfunction
  function automatic int rc(input int i);   return (i == 0) ? 2 : 1; endfunction
  function automatic int sc(input int i);   return (i == 0) ? 4 : 3; endfunction
  function automatic int elen(input int i); return rc(i) + 2 * sc(i) + 1; endfunction

  // Per-evaluation arbiter values; the model knows which evaluation is running from its cycle number.
  logic [1:0] arb_tab [2][5];

  logic        m_active [2];
  int          m_t      [2];
  logic [31:0] m_chal   [2];
  logic [4:0]  m_res    [2];   // {xor, stable[1:0], response[1:0]}

  function automatic int eidx(input int i);
    int e;
    if (!m_active[i]) return 0;
    e = (m_t[i] - 1) / elen(i);
    return (e > ne(i) - 1) ? ne(i) - 1 : e;
  endfunction

  always_comb begin
    arb_a = arb_tab[0][eidx(0)];
    arb_b = arb_tab[1][eidx(1)][0];
  end

  function automatic logic [4:0] calc(input int i);
    int v;
    logic [1:0] r, s;
    r = '0;
    s = '0;
    for (int k = 0; k < nc(i); k++) begin
      v = 0;
      for (int e = 0; e < ne(i); e++) v += int'(arb_tab[i][e][k]);
      r[k] = (v > ne(i) / 2);
      s[k] = (v == 0) || (v == ne(i));
    end
    return {^r, s, r};
  endfunction

  // Model: m_t is the cycle number since the accepting edge (ARB_RST starts at 1, Done at N*E+1).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_t[i]      <= 0;
        m_chal[i]   <= '0;
        m_res[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_active[i]) begin
          if (abort_s[i] || (m_t[i] == ne(i) * elen(i) + 1)) begin
            m_active[i] <= 1'b0;
          end else begin
            m_t[i] <= m_t[i] + 1;
            if (m_t[i] + 1 == ne(i) * elen(i) + 1) m_res[i] <= calc(i);
          end
        end else if (start_s[i] && !abort_s[i]) begin
          m_active[i] <= 1'b1;
          m_t[i]      <= 1;
          m_chal[i]   <= chal_s[i];
        end
      end
    end
  end

  // {busy, pulse, arbreset, done}
  function automatic logic [3:0] exp_ctrl(input int i);
    int p;
    if (!m_active[i]) return 4'b0010;
    if (m_t[i] == ne(i) * elen(i) + 1) return 4'b1001;
    p = (m_t[i] - 1) % elen(i);
    return {1'b1, (p >= rc(i)) && (p < rc(i) + sc(i) + 1), (p < rc(i)), 1'b0};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] e;
      logic in_done;
      e = exp_ctrl(i);
      in_done = e[0];
      chk($sformatf("busy[%0d]", i), {31'd0, o_busy[i]}, {31'd0, e[3]});
      chk($sformatf("done[%0d]", i), {31'd0, o_done[i]}, {31'd0, e[0]});
      if (!in_done) begin
        chk($sformatf("pulse[%0d]", i), {31'd0, o_pulse[i]}, {31'd0, e[2]});
        chk($sformatf("arbreset[%0d]", i), {31'd0, o_arbrst[i]}, {31'd0, e[1]});
      end
      chk($sformatf("pufchal[%0d]", i), o_pc[i], m_chal[i]);
      chk($sformatf("results[%0d]", i), {27'd0, o_xr[i], o_stab[i], o_resp[i]}, {27'd0, m_res[i]});
    end
  end

  // Drives one Start at cycle 0 and watches 80 cycles; extra Start/Abort/reset at given cycles.
  task automatic run(input int i, input logic [31:0] ch, input int ex1, input int ex2,
                     input int abort_at, input int rst_at,
                     output int done_cyc, output int done_cnt,
                     output int first_pulse, output int rst_before);
    @(negedge clk);
    chal_s[i]  = ch;
    start_s[i] = 1'b1;
    done_cyc = -1; done_cnt = 0; first_pulse = -1; rst_before = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start_s[i] = (c == ex1) || (c == ex2);
      abort_s[i] = (c == abort_at);
      if (c == rst_at + 3) rst_n = 1'b1;
      if (o_done[i]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (o_pulse[i] && first_pulse < 0) first_pulse = c;
      if (first_pulse < 0 && o_busy[i] && o_arbrst[i]) rst_before++;
      if (abort_at > 0 && c == abort_at + 1)
        chk("abort_idle", {29'd0, o_busy[i], o_pulse[i], o_arbrst[i]}, 32'd1);
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {o_busy[i], o_pulse[i], o_arbrst[i], o_done[i], o_xr[i], o_resp[i], o_stab[i]},
                              {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
      end
    end
    start_s[i] = 1'b0;
    abort_s[i] = 1'b0;
  endtask

  int dc, dn, fp, rb;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; chal_s[i] = '0;
      for (int e = 0; e < 5; e++) arb_tab[i][e] = 2'b00;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_arbreset", {31'd0, arbrst_a}, 32'd1);
    chk("reset_outputs", {busy_a, pulse_a, done_a, resp_a, stab_a, xr_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Chain 0 tied 1, chain 1 tied 0; extra Starts at cycles 5 and 30 must be ignored.
    for (int e = 0; e < 5; e++) arb_tab[0][e] = 2'b01;
    run(0, 32'hA5A5_0F0F, 5, 30, -1, -1, dc, dn, fp, rb);
    $display("txn tied: done_cycle=%0d dones=%0d resp=%b stab=%b xor=%b", dc, dn, resp_a, stab_a, xr_a);
    chk("tied_done_cycle", dc, 56);
    chk("tied_done_count", dn, 1);
    chk("tied_first_pulse", fp, 3);
    chk("tied_results", {27'd0, xr_a, stab_a, resp_a}, {27'd0, 1'b1, 2'b11, 2'b01});
    chk("tied_pufchal", pc_a, 32'hA5A5_0F0F);

    // Start and Abort together in IDLE: Start dropped.
    @(negedge clk); start_s[0] = 1'b1; abort_s[0] = 1'b1; chal_s[0] = 32'hDEAD_BEEF;
    @(negedge clk); start_s[0] = 1'b0; abort_s[0] = 1'b0;
    chk("start_abort_idle", {31'd0, busy_a}, 32'd0);
    $display("txn start+abort in idle: busy=%b pufchal=%h", busy_a, pc_a);

    // Chain 0 toggles 1,0,1,0,1; chain 1 stays 0.
    arb_tab[0][0] = 2'b01; arb_tab[0][1] = 2'b00; arb_tab[0][2] = 2'b01;
    arb_tab[0][3] = 2'b00; arb_tab[0][4] = 2'b01;
    run(0, 32'h1357_9BDF, -1, -1, -1, -1, dc, dn, fp, rb);
    $display("txn toggle: done_cycle=%0d resp=%b stab=%b xor=%b", dc, resp_a, stab_a, xr_a);
    chk("toggle_done_cycle", dc, 56);
    chk("toggle_results", {27'd0, xr_a, stab_a, resp_a}, {27'd0, 1'b1, 2'b10, 2'b01});

    // Abort at cycle 20: no Done, results held.
    for (int e = 0; e < 5; e++) arb_tab[0][e] = 2'b10;
    run(0, 32'h0F0F_A5A5, -1, -1, 20, -1, dc, dn, fp, rb);
    $display("txn abort: dones=%0d resp=%b stab=%b", dn, resp_a, stab_a);
    chk("abort_no_done", dn, 0);
    chk("abort_results_held", {27'd0, xr_a, stab_a, resp_a}, {27'd0, 1'b1, 2'b10, 2'b01});

    // Reset at cycle 15, then a full evaluation afterwards.
    run(0, 32'h2222_4444, -1, -1, -1, 15, dc, dn, fp, rb);
    $display("txn reset: dones=%0d resp=%b pufchal=%h", dn, resp_a, pc_a);
    chk("reset_no_done", dn, 0);
    chk("reset_results", {27'd0, xr_a, stab_a, resp_a}, 32'd0);
    for (int e = 0; e < 5; e++) arb_tab[0][e] = 2'b11;
    run(0, 32'h6666_8888, -1, -1, -1, -1, dc, dn, fp, rb);
    $display("txn after reset: done_cycle=%0d resp=%b stab=%b xor=%b", dc, resp_a, stab_a, xr_a);
    chk("post_reset_done_cycle", dc, 56);
    chk("post_reset_results", {27'd0, xr_a, stab_a, resp_a}, {27'd0, 1'b0, 2'b11, 2'b11});

    // Minimal configuration: one evaluation, ArbResult 0.
    arb_tab[1][0] = 2'b00;
    run(1, 32'h1234_5678, -1, -1, -1, -1, dc, dn, fp, rb);
    $display("txn small: done_cycle=%0d first_pulse=%0d arbreset_cycles=%0d resp=%b stab=%b", dc, fp, rb, resp_b, stab_b);
    chk("small_done_cycle", dc, 9);
    chk("small_first_pulse", fp, 2);
    chk("small_arbreset_len", rb, 1);
    chk("small_results", {30'd0, resp_b, stab_b}, 32'b01);
    chk("small_pufchal", pc_b, 32'h1234_5678);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
